// File: rtl/subunit_seq_pkg.sv
// Shared types for the sub-unit sequencer: FSM state encoding and default unit count.
package subunit_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

    localparam int NUM_UNITS_DEF = 5;

endpackage

// File: rtl/subunit_sequencer_next_sel.sv
// Priority search over the enable mask: the lowest set bit (first=1) or the
// lowest set bit strictly above the current index (first=0).
module seq_next_sel #(
    parameter int NUM_UNITS = 5,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_UNITS-1:0] mask,
    input  logic [IDX_W-1:0]     idx,
    input  logic                 first,
    output logic [IDX_W-1:0]     next_idx,
    output logic                 valid
);

    // Scan downwards so the lowest qualifying bit is the last one written and wins.
    always_comb begin
        next_idx = {IDX_W{1'b0}};
        valid    = 1'b0;
        for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            if (mask[k] && (first || (k > int'(idx)))) begin
                next_idx = IDX_W'(k);
                valid    = 1'b1;
            end else begin
                next_idx = next_idx;
                valid    = valid;
            end
        end
    end

endmodule

// File: rtl/subunit_sequencer.sv
// Sequences NUM_UNITS child sub-units one at a time in index order: launches each
// enabled unit with a one-cycle start pulse and waits for its done, with a per-unit
// timeout and an external abort. All outputs come straight from flops.
module subunit_sequencer
    import subunit_seq_pkg::*;
#(
    parameter int NUM_UNITS   = NUM_UNITS_DEF,
    parameter int TIMEOUT_CYC = 200,
    parameter int TO_W        = 8,
    localparam int IDX_W      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [NUM_UNITS-1:0] enable_mask_i,
    input  logic                 abort_i,
    output logic [NUM_UNITS-1:0] unit_start_o,
    input  logic [NUM_UNITS-1:0] unit_done_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [IDX_W-1:0]     err_unit_o
);

    seq_state_t           state_r, state_nxt_s;
    logic [NUM_UNITS-1:0] mask_r, mask_nxt_s;
    logic [IDX_W-1:0]     idx_r, idx_nxt_s;
    logic [TO_W-1:0]      cnt_r, cnt_nxt_s;
    logic                 error_r, error_nxt_s;
    logic [IDX_W-1:0]     err_unit_r, err_unit_nxt_s;
    logic [NUM_UNITS-1:0] unit_start_r, unit_start_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 done_r, done_nxt_s;

    logic [NUM_UNITS-1:0] sel_mask_s;
    logic                 sel_first_s;
    logic [IDX_W-1:0]     sel_idx_s;
    logic                 sel_valid_s;

    // In IDLE the search runs on the incoming mask so the first launch needs no extra cycle.
    assign sel_first_s = (state_r == IDLE);
    assign sel_mask_s  = sel_first_s ? enable_mask_i : mask_r;

    seq_next_sel #(
        .NUM_UNITS (NUM_UNITS),
        .IDX_W     (IDX_W)
    ) u_next_sel (
        .mask     (sel_mask_s),
        .idx      (idx_r),
        .first    (sel_first_s),
        .next_idx (sel_idx_s),
        .valid    (sel_valid_s)
    );

    // Next-state and next-output logic; outputs are precomputed here and registered below.
    always_comb begin
        state_nxt_s    = state_r;
        mask_nxt_s     = mask_r;
        idx_nxt_s      = idx_r;
        cnt_nxt_s      = cnt_r;
        error_nxt_s    = error_r;
        err_unit_nxt_s = err_unit_r;

        case (state_r)
            IDLE: begin
                if (start_i) begin
                    mask_nxt_s     = enable_mask_i;
                    error_nxt_s    = 1'b0;
                    err_unit_nxt_s = {IDX_W{1'b0}};
                    if (sel_valid_s) begin
                        state_nxt_s = LAUNCH;
                        idx_nxt_s   = sel_idx_s;
                    end else begin
                        state_nxt_s = FINISH;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LAUNCH: begin
                if (abort_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                    cnt_nxt_s   = {TO_W{1'b0}};
                end
            end
            WAIT: begin
                cnt_nxt_s = cnt_r + TO_W'(1);
                if (abort_i) begin
                    state_nxt_s = IDLE;
                end else if (unit_done_i[idx_r]) begin
                    // A done arriving on the timeout cycle still counts as success.
                    if (sel_valid_s) begin
                        state_nxt_s = LAUNCH;
                        idx_nxt_s   = sel_idx_s;
                    end else begin
                        state_nxt_s = FINISH;
                    end
                end else if ((cnt_r + TO_W'(1)) == TO_W'(TIMEOUT_CYC)) begin
                    state_nxt_s    = FINISH;
                    error_nxt_s    = 1'b1;
                    err_unit_nxt_s = idx_r;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            FINISH: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        if (state_nxt_s == LAUNCH) begin
            unit_start_nxt_s = NUM_UNITS'(1) << idx_nxt_s;
        end else begin
            unit_start_nxt_s = {NUM_UNITS{1'b0}};
        end
        busy_nxt_s = (state_nxt_s == LAUNCH) || (state_nxt_s == WAIT);
        done_nxt_s = (state_nxt_s == FINISH);
    end

    // State, sequence context and registered outputs; reset drops everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            mask_r       <= {NUM_UNITS{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            cnt_r        <= {TO_W{1'b0}};
            error_r      <= 1'b0;
            err_unit_r   <= {IDX_W{1'b0}};
            unit_start_r <= {NUM_UNITS{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            mask_r       <= mask_nxt_s;
            idx_r        <= idx_nxt_s;
            cnt_r        <= cnt_nxt_s;
            error_r      <= error_nxt_s;
            err_unit_r   <= err_unit_nxt_s;
            unit_start_r <= unit_start_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
        end
    end

    assign unit_start_o = unit_start_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign error_o      = error_r;
    assign err_unit_o   = err_unit_r;

endmodule

// File: tb/tb_subunit_sequencer.sv
// Randomized self-checking bench for subunit_sequencer. For each sequence a
// timeline model builds the expected per-cycle outputs from the mask, the
// per-unit done latencies and the abort point; the bench then replays it.
module tb_subunit_sequencer;

    localparam int N    = 5;
    localparam int TO   = 4;
    localparam int MAXC = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [N-1:0] enable_mask_i;
    logic         abort_i;
    logic [N-1:0] unit_start_o;
    logic [N-1:0] unit_done_i;
    logic         busy_o;
    logic         done_o;
    logic         error_o;
    logic [2:0]   err_unit_o;

    subunit_sequencer #(
        .NUM_UNITS   (N),
        .TIMEOUT_CYC (TO),
        .TO_W        (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .enable_mask_i (enable_mask_i),
        .abort_i       (abort_i),
        .unit_start_o  (unit_start_o),
        .unit_done_i   (unit_done_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .err_unit_o    (err_unit_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // expected timeline, indexed by cycle relative to the start cycle (cycle 0)
    logic [N-1:0] e_ustart [MAXC];
    bit           e_busy   [MAXC];
    bit           e_done   [MAXC];
    bit           e_err    [MAXC];
    int           e_eunit  [MAXC];
    int           w_unit   [MAXC];   // unit waiting in this cycle, -1 if none
    bit           w_hit    [MAXC];   // that unit signals done in this cycle
    int           lat_cfg  [N];      // WAIT cycles until done; > TO means never
    int           end_c;
    int           abort_c;
    bit           prev_err;
    int           prev_eunit;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    endtask

    // abort_sel: -1 none, 0..N-1 abort on that unit's done cycle, N = random busy cycle
    task automatic build_model(input logic [N-1:0] mask, input int abort_sel);
        int c;
        bit stop;
        int busy_list[$];
        for (int i = 0; i < MAXC; i++) begin
            e_ustart[i] = '0;
            e_busy[i]   = 1'b0;
            e_done[i]   = 1'b0;
            e_err[i]    = (i == 0) ? prev_err : 1'b0;
            e_eunit[i]  = (i == 0) ? prev_eunit : 0;
            w_unit[i]   = -1;
            w_hit[i]    = 1'b0;
        end
        c = 1;
        stop = 1'b0;
        abort_c = -1;
        for (int k = 0; k < N; k++) begin
            if (mask[k] && !stop) begin
                e_ustart[c][k] = 1'b1;
                e_busy[c] = 1'b1;
                busy_list.push_back(c);
                if (lat_cfg[k] <= TO) begin
                    for (int w = 1; w <= lat_cfg[k]; w++) begin
                        e_busy[c+w] = 1'b1;
                        w_unit[c+w] = k;
                        busy_list.push_back(c + w);
                    end
                    w_hit[c+lat_cfg[k]] = 1'b1;
                    if (abort_sel == k) abort_c = c + lat_cfg[k];
                    c = c + lat_cfg[k] + 1;
                end else begin
                    for (int w = 1; w <= TO; w++) begin
                        e_busy[c+w] = 1'b1;
                        w_unit[c+w] = k;
                        busy_list.push_back(c + w);
                    end
                    c = c + TO + 1;
                    stop = 1'b1;
                    for (int i = c; i < MAXC; i++) begin
                        e_err[i]   = 1'b1;
                        e_eunit[i] = k;
                    end
                end
            end
        end
        e_done[c] = 1'b1;
        end_c = c;
        if (abort_sel == N && busy_list.size() > 0)
            abort_c = busy_list[$urandom_range(0, busy_list.size() - 1)];
        if (abort_c >= 0) begin
            for (int i = abort_c + 1; i < MAXC; i++) begin
                e_ustart[i] = '0;
                e_busy[i]   = 1'b0;
                e_done[i]   = 1'b0;
                e_err[i]    = 1'b0;
                e_eunit[i]  = 0;
            end
            end_c = abort_c;
        end
    endtask

    task automatic run_seq(input logic [N-1:0] mask, input int abort_sel, input bit noise);
        int last;
        logic [N-1:0] dv;
        build_model(mask, abort_sel);
        last = end_c + 2;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) start_i = 1'b1;
            else if (noise && c <= end_c) start_i = 1'($urandom() % 2);
            else start_i = 1'b0;
            enable_mask_i = (c == 0 || !noise) ? mask : N'($urandom());
            if (c == abort_c) abort_i = 1'b1;
            else if (noise && (c == 0 || c > end_c || (c == end_c && abort_c < 0)))
                abort_i = 1'($urandom() % 2);
            else abort_i = 1'b0;
            dv = noise ? N'($urandom()) : '0;
            if (w_unit[c] >= 0) dv[w_unit[c]] = w_hit[c];
            unit_done_i = dv;
            @(negedge clk);
            check_val("unit_start", int'(unit_start_o), int'(e_ustart[c]));
            check_val("busy", int'(busy_o), int'(e_busy[c]));
            check_val("done", int'(done_o), int'(e_done[c]));
            check_val("error", int'(error_o), int'(e_err[c]));
            check_val("err_unit", int'(err_unit_o), e_eunit[c]);
        end
        prev_err   = e_err[last];
        prev_eunit = e_eunit[last];
        start_i = 1'b0;
        abort_i = 1'b0;
        unit_done_i = '0;
    endtask

    task automatic set_lat(input int v);
        for (int k = 0; k < N; k++) lat_cfg[k] = v;
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        enable_mask_i = '0;
        abort_i = 1'b0;
        unit_done_i = '0;
        prev_err = 1'b0;
        prev_eunit = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_unit_start", int'(unit_start_o), 0);
        check_val("rst_busy", int'(busy_o), 0);
        check_val("rst_done", int'(done_o), 0);
        check_val("rst_error", int'(error_o), 0);
        check_val("rst_err_unit", int'(err_unit_o), 0);
        rst = 1'b0;

        // all units, fixed latency
        set_lat(3);
        run_seq(5'b11111, -1, 1'b0);
        // sparse mask: only units 2 and 4
        run_seq(5'b10100, -1, 1'b0);
        // empty mask: immediate done
        run_seq(5'b00000, -1, 1'b0);
        // unit 1 never finishes -> timeout, then a clean run clears the error
        lat_cfg[1] = 99;
        run_seq(5'b11111, -1, 1'b0);
        set_lat(3);
        run_seq(5'b11111, -1, 1'b0);
        // abort coincident with unit 3 done
        run_seq(5'b11111, 3, 1'b0);
        // repeated start, foreign done bits and mask changes while busy
        run_seq(5'b11111, -1, 1'b1);
        // done arriving exactly on the timeout cycle still succeeds
        set_lat(TO);
        run_seq(5'b01011, -1, 1'b0);

        // asynchronous reset in the middle of a sequence
        set_lat(3);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        enable_mask_i = 5'b11111;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        check_val("pre_rst_busy", int'(busy_o), 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_busy", int'(busy_o), 0);
        check_val("async_rst_unit_start", int'(unit_start_o), 0);
        check_val("async_rst_done", int'(done_o), 0);
        @(negedge clk);
        rst = 1'b0;
        prev_err = 1'b0;
        prev_eunit = 0;

        // randomized sequences
        for (int s = 0; s < 60; s++) begin
            for (int k = 0; k < N; k++)
                lat_cfg[k] = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(1, TO));
            run_seq(N'($urandom()), ($urandom_range(0, 3) == 0) ? N : -1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
